// File: rtl/batcharger_pkg.sv
// Shared types, default thresholds and current arithmetic for the Li-Po charge-mode controller.
package batcharger_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StTc   = 3'd1,
        StCc   = 3'd2,
        StCv   = 3'd3,
        StDone = 3'd4
    } chg_state_e;

    localparam logic [7:0]  VPRESET_DEF  = 8'd153;
    localparam logic [7:0]  VFLOAT_DEF   = 8'd214;
    localparam logic [7:0]  VRECH_DEF    = 8'd209;
    localparam logic [7:0]  TEMP_MIN_DEF = 8'd40;
    localparam logic [7:0]  TEMP_MAX_DEF = 8'd200;
    localparam logic [7:0]  ICC_UNIT_DEF = 8'd12;
    localparam logic [23:0] CV_TMAX_DEF  = 24'd10_000_000;

    // 4x8-bit product always fits in 12 bits; clamp to the 8-bit DAC range.
    function automatic logic [7:0] icc_sat(input logic [3:0] sel, input logic [7:0] unit);
        logic [11:0] prod;
        prod = 12'(sel) * 12'(unit);
        return (prod > 12'd255) ? 8'hFF : prod[7:0];
    endfunction

endpackage

// File: rtl/batcharger_cv_timer.sv
// CV dwell counter: runs while the controller sits in CV and flags the terminal count.
module batcharger_cv_timer #(
    parameter logic [23:0] CV_TMAX = 24'd10_000_000
) (
    input  logic clk,
    input  logic rstz,
    input  logic run,
    output logic hit
);

    logic [23:0] count_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + 24'd1;
        end else begin
            count_q <= '0;
        end
    end

    assign hit = run && (count_q == CV_TMAX - 24'd1);

endmodule

// File: rtl/batcharger_ctrl.sv
// Charge-mode sequencer (IDLE/TC/CC/CV/DONE) driving mode flags and DAC codes.
// Optional CV timeout guarded by BATCHARGER_CV_TIMEOUT_EN.
module batcharger_ctrl
    import batcharger_pkg::*;
#(
    parameter logic [7:0]  VPRESET  = VPRESET_DEF,
    parameter logic [7:0]  VFLOAT   = VFLOAT_DEF,
    parameter logic [7:0]  VRECH    = VRECH_DEF,
    parameter logic [7:0]  TEMP_MIN = TEMP_MIN_DEF,
    parameter logic [7:0]  TEMP_MAX = TEMP_MAX_DEF,
    parameter logic [7:0]  ICC_UNIT = ICC_UNIT_DEF,
    parameter logic [23:0] CV_TMAX  = CV_TMAX_DEF
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       en,
    input  logic [3:0] sel,
    input  logic       adc_valid,
    input  logic [7:0] vbat,
    input  logic [7:0] ibat,
    input  logic [7:0] vtbat,
    output logic       tc,
    output logic       cc,
    output logic       cv,
    output logic       done,
    output logic [7:0] imc,
    output logic [7:0] vmc,
    output logic       timeout
);

    chg_state_e state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic       temp_ok;
    logic       tmo_hit;
    logic [7:0] iend;
    logic [7:0] icc_nxt, itc_nxt;
    logic [7:0] imc_d, vmc_d;
    logic       timeout_d;

    assign temp_ok = (vtbat >= TEMP_MIN) && (vtbat <= TEMP_MAX);
    assign iend    = icc_sat(sel_q, ICC_UNIT) >> 4;

`ifdef BATCHARGER_CV_TIMEOUT_EN
    batcharger_cv_timer #(
        .CV_TMAX (CV_TMAX)
    ) u_cv_timer (
        .clk  (clk),
        .rstz (rstz),
        .run  (state_q == StCv),
        .hit  (tmo_hit)
    );

    always_comb begin
        timeout_d = timeout;
        if (state_d == StIdle) begin
            timeout_d = 1'b0;
        end else if (tmo_hit) begin
            timeout_d = 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^CV_TMAX;
    assign tmo_hit    = 1'b0;
    assign timeout_d  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (!en) begin
            state_d = StIdle;
        end else if (adc_valid && (state_q != StIdle) && !temp_ok) begin
            state_d = StIdle;
        end else if (tmo_hit) begin
            state_d = StDone;
        end else if (adc_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (temp_ok && (sel != 4'd0)) begin
                        sel_d = sel;
                        if (vbat < VPRESET) begin
                            state_d = StTc;
                        end else if (vbat < VFLOAT) begin
                            state_d = StCc;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StTc: if (vbat >= VPRESET) state_d = StCc;
                StCc: if (vbat >= VFLOAT) state_d = StCv;
                StCv: if (ibat <= iend) state_d = StDone;
                StDone: begin
                    if (vbat < VPRESET) begin
                        state_d = StTc;
                    end else if (vbat < VRECH) begin
                        state_d = StCc;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // DAC codes follow the state being entered, using the sel latched on this edge.
    always_comb begin
        icc_nxt = icc_sat(sel_d, ICC_UNIT);
        itc_nxt = icc_nxt >> 3;
        if (itc_nxt == 8'd0) begin
            itc_nxt = 8'd1;
        end
        imc_d = 8'd0;
        vmc_d = 8'd0;
        unique case (state_d)
            StTc: begin
                imc_d = itc_nxt;
                vmc_d = VFLOAT;
            end
            StCc, StCv: begin
                imc_d = icc_nxt;
                vmc_d = VFLOAT;
            end
            default: begin
                imc_d = 8'd0;
                vmc_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= StIdle;
            sel_q   <= 4'd0;
            tc      <= 1'b0;
            cc      <= 1'b0;
            cv      <= 1'b0;
            done    <= 1'b0;
            imc     <= 8'd0;
            vmc     <= 8'd0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tc      <= (state_d == StTc);
            cc      <= (state_d == StCc);
            cv      <= (state_d == StCv);
            done    <= (state_d == StDone);
            imc     <= imc_d;
            vmc     <= vmc_d;
            timeout <= timeout_d;
        end
    end

endmodule
